// File: rtl/chunked_seq_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per clock with a
// registered inter-chunk carry, plus signed overflow and start/busy/done handshake.
module chunked_seq_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic             C_in,
    output logic [WIDTH-1:0] sum,
    output logic             C_out,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic               cout_q;
    logic               ovf_q;
    logic               busy_q;
    logic               done_q;

    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk;
    logic [CHUNK:0]     chunk_d;

    // The single CHUNK-bit adder shared by every slice of the operation.
    always_comb begin
        a_chunk = a_q[int'(idx_q) * CHUNK +: CHUNK];
        b_chunk = b_q[int'(idx_q) * CHUNK +: CHUNK];
        chunk_d = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // Subtraction is A + ~B + 1, so only the operand and carry-in differ.
                        a_q     <= A_in;
                        b_q     <= sub ? ~B_in : B_in;
                        carry_q <= sub ? 1'b1 : C_in;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    sum_q[int'(idx_q) * CHUNK +: CHUNK] <= chunk_d[CHUNK-1:0];
                    carry_q <= chunk_d[CHUNK];
                    idx_q   <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= chunk_d[CHUNK];
                        ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                   (chunk_d[CHUNK-1] != a_q[WIDTH-1]);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign sum      = sum_q;
    assign C_out    = cout_q;
    assign overflow = ovf_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Scoreboard bench for chunked_seq_adder: a 4-chunk instance and a single-chunk instance.
module tb_chunked_seq_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic        sub = 1'b0;
    logic        C_in = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;

    logic [31:0] sum0, sum1;
    logic        cout0, cout1, ovf0, ovf1, busy0, busy1, done0, done1;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        v;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    chunked_seq_adder #(.WIDTH(32), .CHUNK(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .sub(sub),
        .A_in(A), .B_in(B), .C_in(C_in),
        .sum(sum0), .C_out(cout0), .overflow(ovf0), .busy(busy0), .done(done0)
    );

    chunked_seq_adder #(.WIDTH(32), .CHUNK(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub),
        .A_in(A), .B_in(B), .C_in(C_in),
        .sum(sum1), .C_out(cout1), .overflow(ovf1), .busy(busy1), .done(done1)
    );

    // Arithmetic reference: unsigned carry/borrow and signed overflow by definition.
    function automatic exp_t model(bit sb, logic [31:0] a, logic [31:0] b, bit cin);
        exp_t        e;
        logic [32:0] full;
        if (sb) begin
            e.s = a - b;
            e.c = (a >= b);
            e.v = (a[31] != b[31]) && (e.s[31] != a[31]);
        end else begin
            full = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            e.s = full[31:0];
            e.c = full[32];
            e.v = (a[31] == b[31]) && (e.s[31] != a[31]);
        end
        return e;
    endfunction

    task automatic issue(bit sel, bit sb, logic [31:0] a, logic [31:0] b, bit cin);
        sub  = sb;
        A    = a;
        B    = b;
        C_in = cin;
        if (sel) begin
            start1 = 1'b1;
            q1.push_back(model(sb, a, b, cin));
        end else begin
            start0 = 1'b1;
            q0.push_back(model(sb, a, b, cin));
        end
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        A    = $urandom;
        B    = $urandom;
        C_in = 1'($urandom);
        sub  = 1'($urandom);
    endtask

    task automatic wait_done(bit sel, output int lat, output int bcnt, output bit tmo);
        lat  = 0;
        bcnt = 0;
        tmo  = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (sel ? busy1 : busy0) bcnt++;
            if (sel ? done1 : done0) begin
                tmo = 1'b0;
                break;
            end
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (sum0 !== 32'd0) begin
            errs++;
            $display("FAIL reset_sum0 got=%h exp=0", sum0);
        end
        checks++;
        if ({cout0, ovf0, busy0, done0} !== 4'b0) begin
            errs++;
            $display("FAIL reset_flags0 got=%b exp=0000", {cout0, ovf0, busy0, done0});
        end
        checks++;
        if ({sum1, cout1, ovf1, busy1, done1} !== 36'd0) begin
            errs++;
            $display("FAIL reset_dut1 got=%h exp=0", {sum1, cout1, ovf1, busy1, done1});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int   lat, bc;
        bit   tmo;
        exp_t e, got;
        issue(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        wait_done(1'b0, lat, bc, tmo);
        e   = q0.pop_front();
        got = {sum0, cout0, ovf0};
        checks++;
        if (tmo || lat != 4) begin
            errs++;
            $display("FAIL basic_latency got=%0d exp=4 timeout=%0d", lat, tmo);
        end
        checks++;
        if (bc != 4) begin
            errs++;
            $display("FAIL basic_busy_cycles got=%0d exp=4", bc);
        end
        checks++;
        if (got !== e) begin
            errs++;
            $display("FAIL basic_result got=%h/%b/%b exp=%h/%b/%b", got.s, got.c, got.v, e.s, e.c, e.v);
        end
        @(negedge clk);
        checks++;
        if (done0 !== 1'b0 || sum0 !== e.s) begin
            errs++;
            $display("FAIL basic_done_pulse done=%b sum=%h exp done=0 sum=%h", done0, sum0, e.s);
        end
    endtask

    task automatic test_add(bit sel, int exp_lat);
        logic [31:0] av[3] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'd7};
        logic [31:0] bv[3] = '{32'd1, 32'd1, 32'd9};
        bit          cv[3] = '{1'b0, 1'b0, 1'b1};
        int   lat, bc;
        bit   tmo;
        exp_t e, got;
        for (int i = 0; i < 3; i++) begin
            issue(sel, 1'b0, av[i], bv[i], cv[i]);
            wait_done(sel, lat, bc, tmo);
            if (sel) e = q1.pop_front();
            else     e = q0.pop_front();
            got = sel ? {sum1, cout1, ovf1} : {sum0, cout0, ovf0};
            checks++;
            if (tmo || lat != exp_lat) begin
                errs++;
                $display("FAIL add%0d_latency dut=%0d got=%0d exp=%0d", i, sel, lat, exp_lat);
            end
            checks++;
            if (got.s !== e.s) begin
                errs++;
                $display("FAIL add%0d_sum dut=%0d got=%h exp=%h", i, sel, got.s, e.s);
            end
            checks++;
            if (got.c !== e.c || got.v !== e.v) begin
                errs++;
                $display("FAIL add%0d_flags dut=%0d got c=%b v=%b exp c=%b v=%b", i, sel, got.c, got.v, e.c, e.v);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sub(bit sel, int exp_lat);
        logic [31:0] av[2] = '{32'd5, 32'h8000_0000};
        logic [31:0] bv[2] = '{32'd7, 32'd1};
        int   lat, bc;
        bit   tmo;
        exp_t e, got;
        for (int i = 0; i < 2; i++) begin
            issue(sel, 1'b1, av[i], bv[i], 1'b0);
            wait_done(sel, lat, bc, tmo);
            if (sel) e = q1.pop_front();
            else     e = q0.pop_front();
            got = sel ? {sum1, cout1, ovf1} : {sum0, cout0, ovf0};
            checks++;
            if (tmo || lat != exp_lat) begin
                errs++;
                $display("FAIL sub%0d_latency dut=%0d got=%0d exp=%0d", i, sel, lat, exp_lat);
            end
            checks++;
            if (got !== e) begin
                errs++;
                $display("FAIL sub%0d_result dut=%0d got=%h/%b/%b exp=%h/%b/%b", i, sel, got.s, got.c, got.v, e.s, e.c, e.v);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_protocol();
        int   lat, bc;
        bit   tmo;
        exp_t e;
        issue(1'b0, 1'b0, 32'd3, 32'd4, 1'b0);
        @(posedge clk);
        #1;
        start0 = 1'b1;
        sub    = 1'b0;
        A      = 32'd100;
        B      = 32'd100;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        wait_done(1'b0, lat, bc, tmo);
        e = q0.pop_front();
        checks++;
        if (tmo || lat != 2 || sum0 !== e.s) begin
            errs++;
            $display("FAIL ignored_start got sum=%h lat=%0d exp sum=%h lat=2", sum0, lat, e.s);
        end
        // Still in the done cycle: this start must be accepted immediately.
        issue(1'b0, 1'b0, 32'd6, 32'd10, 1'b0);
        wait_done(1'b0, lat, bc, tmo);
        e = q0.pop_front();
        checks++;
        if (tmo || lat != 4) begin
            errs++;
            $display("FAIL back_to_back_latency got=%0d exp=4 timeout=%0d", lat, tmo);
        end
        checks++;
        if (sum0 !== e.s || cout0 !== e.c || ovf0 !== e.v) begin
            errs++;
            $display("FAIL back_to_back_result got=%h exp=%h", sum0, e.s);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        bit seen;
        issue(1'b0, 1'b0, 32'd3, 32'd4, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q0.delete();
        @(negedge clk);
        checks++;
        if ({sum0, cout0, ovf0, busy0, done0} !== 36'd0) begin
            errs++;
            $display("FAIL abort_outputs got sum=%h flags=%b exp all 0", sum0, {cout0, ovf0, busy0, done0});
        end
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done0 || busy0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errs++;
            $display("FAIL abort_stays_idle got done/busy activity exp none");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_add(1'b0, 4);
        test_sub(1'b0, 4);
        test_protocol();
        test_reset_abort();
        test_add(1'b1, 1);
        test_sub(1'b1, 1);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
